// File: rtl/proj_fragment_server.sv
// Fragment server: returns the FRAG_LEN-bit window of a bit-addressed store at a signed bit offset.
// Latency: request accepted in cycle T, rsp_valid in cycle T+4; one request every 5 cycles at best.
// Backpressure: req_ready only in IDLE; the response is held stable in RESP until rsp_ready.
//
// Ports: clk/rst (sync, active-high); req_valid/req_ready/req_index request channel;
//        mem_rd_en/mem_addr/mem_rdata synchronous store read (data one cycle after strobe);
//        rsp_valid/rsp_ready/rsp_fragment/rsp_padded response channel.
// Optional: define FRAG_SRV_STATS_EN to add stat_served/stat_padded saturating counters.
module proj_fragment_server #(
   parameter int FRAG_LEN          = 8,
   parameter int MEM_WIDTH         = 32,
   parameter int MEM_DEPTH         = 32,
   parameter int SIGNED_INDICE_LEN = 11,
   parameter int ADDR_LEN          = $clog2(MEM_DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [SIGNED_INDICE_LEN-1:0] req_index,
   output logic                         mem_rd_en,
   output logic [ADDR_LEN-1:0]          mem_addr,
   input  logic [MEM_WIDTH-1:0]         mem_rdata,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [FRAG_LEN-1:0]          rsp_fragment,
   output logic                         rsp_padded
`ifdef FRAG_SRV_STATS_EN
   ,
   output logic [15:0]                  stat_served,
   output logic [15:0]                  stat_padded
`endif
);

   localparam int LOG2W = $clog2(MEM_WIDTH);
   localparam int IW    = SIGNED_INDICE_LEN + 1;   // one extra bit so w0+1 never overflows
   localparam int TOTAL = MEM_WIDTH * MEM_DEPTH;

   typedef enum logic [2:0] {IDLE, RD0, RD1, CAP, RESP} state_t;

   state_t                 state_q, state_d;
   logic signed [IW-1:0]   idx_x, w0_d, w0_q, w1;
   logic [LOG2W-1:0]       off_d, off_q;
   logic                   need1_d, need1_q;
   logic                   pad_d, pad_q;
   logic                   rd_q;      // a read was issued last cycle, so mem_rdata is meaningful
   logic [MEM_WIDTH-1:0]   lo_q, hi;
   logic [FRAG_LEN-1:0]    frag_d;
   logic                   rd0_ok, rd1_ok;
   logic signed [31:0]     idx_i;

   // Word index must lie in [0, MEM_DEPTH); compared in 32-bit signed space.
   function automatic logic in_mem(input logic signed [IW-1:0] w);
      logic signed [31:0] wx;
      wx = 32'(w);
      return (wx >= 0) && (wx < MEM_DEPTH);
   endfunction

   // Request decode, evaluated at accept time.
   always_comb begin
      idx_x   = {req_index[SIGNED_INDICE_LEN-1], req_index};
      w0_d    = idx_x >>> LOG2W;                 // floor division by MEM_WIDTH
      off_d   = req_index[LOG2W-1:0];
      need1_d = (32'(off_d) + FRAG_LEN) > MEM_WIDTH;
      idx_i   = 32'(signed'(req_index));
      pad_d   = (idx_i < 0) || ((idx_i + FRAG_LEN) > TOTAL);
   end

   assign w1     = w0_q + IW'(1);
   assign rd0_ok = in_mem(w0_q);
   assign rd1_ok = need1_q && in_mem(w1);

   // Shift the two-word window down by the bit offset; the cast keeps the low FRAG_LEN bits.
   assign hi     = rd_q ? mem_rdata : '0;
   assign frag_d = FRAG_LEN'({hi, lo_q} >> off_q);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      mem_rd_en = 1'b0;
      mem_addr  = '0;
      rsp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = RD0;
         end
         RD0: begin
            if (rd0_ok) begin
               mem_rd_en = 1'b1;
               mem_addr  = w0_q[ADDR_LEN-1:0];
            end
            state_d = RD1;
         end
         RD1: begin
            if (rd1_ok) begin
               mem_rd_en = 1'b1;
               mem_addr  = w1[ADDR_LEN-1:0];
            end
            state_d = CAP;
         end
         CAP: state_d = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w0_q         <= '0;
         off_q        <= '0;
         need1_q      <= 1'b0;
         pad_q        <= 1'b0;
         rd_q         <= 1'b0;
         lo_q         <= '0;
         rsp_fragment <= '0;
         rsp_padded   <= 1'b0;
      end else begin
         if (state_q == IDLE && req_valid) begin
            w0_q    <= w0_d;
            off_q   <= off_d;
            need1_q <= need1_d;
            pad_q   <= pad_d;
         end
         if (state_q == RD0) rd_q <= rd0_ok;
         if (state_q == RD1) begin
            lo_q <= rd_q ? mem_rdata : '0;
            rd_q <= rd1_ok;
         end
         if (state_q == CAP) begin
            rsp_fragment <= frag_d;
            rsp_padded   <= pad_q;
            rd_q         <= 1'b0;
         end
      end
   end

`ifdef FRAG_SRV_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_served <= '0;
         stat_padded <= '0;
      end else if (rsp_valid && rsp_ready) begin
         if (stat_served != 16'hFFFF) stat_served <= stat_served + 16'd1;
         if (rsp_padded && stat_padded != 16'hFFFF) stat_padded <= stat_padded + 16'd1;
      end
   end
`endif

endmodule
